// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the product accumulator: field layout, special
// encodings, FSM state codes and pack/unpack helpers.
package fp32_pkg;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned EXP_W   = 8;
    localparam int unsigned FRAC_W  = 23;
    localparam int unsigned MANT_W  = 24;
    localparam int unsigned SUM_W   = 25;
    localparam int unsigned LZ_W    = 5;
    localparam int unsigned BIAS    = 127;
    localparam int unsigned EXP_MAX = 255;

    localparam logic [XLEN-1:0] QNAN = 32'h7FC0_0000;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ALIGN = 3'd1;
    localparam logic [2:0] ST_ADD   = 3'd2;
    localparam logic [2:0] ST_NORM  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    function automatic fp32_t unpack(input logic [XLEN-1:0] word);
        return fp32_t'(word);
    endfunction

    function automatic logic [XLEN-1:0] pack(input logic sign, input logic [EXP_W-1:0] exp,
                                             input logic [FRAC_W-1:0] frac);
        return {sign, exp, frac};
    endfunction
endpackage

// File: rtl/fp_product_accumulator_if.sv
// Product input handshake plus accumulator result/status bundle.
interface fp_product_accumulator_if;
    import fp32_pkg::*;

    logic            clear;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_data;
    logic [XLEN-1:0] acc_out;
    logic            out_valid;
    logic            busy;
    logic            overflow;
    logic            underflow;
    logic            exception;

    modport master (
        output clear, in_valid, in_data,
        input  in_ready, acc_out, out_valid, busy, overflow, underflow, exception
    );

    modport slave (
        input  clear, in_valid, in_data,
        output in_ready, acc_out, out_valid, busy, overflow, underflow, exception
    );
endinterface

// File: rtl/fp32_lzc.sv
// Combinational leading-zero counter over the 25-bit adder result (25 when all zero).
module fp32_lzc
    import fp32_pkg::*;
(
    input  logic [SUM_W-1:0] value,
    output logic [LZ_W-1:0]  count
);
    logic found;

    always_comb begin
        count = LZ_W'(SUM_W);
        found = 1'b0;
        for (int i = SUM_W - 1; i >= 0; i--) begin
            if (!found && value[i]) begin
                count = LZ_W'(SUM_W - 1 - i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fp_product_accumulator.sv
// Running FP32 accumulator: four-stage align/add/normalise/write sequence,
// truncating rounding, flush-to-zero denormals and sticky status flags.
module fp_product_accumulator
    import fp32_pkg::*;
(
    input  logic clk,
    input  logic rst,
    fp_product_accumulator_if.slave bus
);
    logic [2:0]        state, state_nx;
    fp32_t             op_a, op_b;
    logic              al_sign, al_sub;
    logic [EXP_W-1:0]  al_exp;
    logic [MANT_W-1:0] al_big, al_small;
    logic              sum_sign;
    logic [EXP_W-1:0]  sum_exp;
    logic [SUM_W-1:0]  sum_mant;
    logic              nrm_sign, nrm_zero;
    logic [9:0]        nrm_exp;
    logic [FRAC_W-1:0] nrm_frac;
    logic [XLEN-1:0]   acc;
    logic              out_valid, overflow, underflow, exception;
    logic              transfer;

    assign bus.in_ready  = (state == ST_IDLE) && !bus.clear;
    assign transfer      = bus.in_valid && bus.in_ready;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.acc_out   = acc;
    assign bus.out_valid = out_valid;
    assign bus.overflow  = overflow;
    assign bus.underflow = underflow;
    assign bus.exception = exception;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (bus.clear) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (transfer) state_nx = ST_ALIGN;
                ST_ALIGN: state_nx = ST_ADD;
                ST_ADD:   state_nx = ST_NORM;
                ST_NORM:  state_nx = ST_WRITE;
                ST_WRITE: state_nx = ST_IDLE;
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    // Alignment: zero-exponent operands are flushed, larger magnitude becomes the base.
    logic              a_big;
    logic [MANT_W-1:0] a_mant, b_mant, small_mant;
    logic [EXP_W-1:0]  big_exp, diff;

    always_comb begin
        a_mant     = (op_a.exp != '0) ? {1'b1, op_a.frac} : '0;
        b_mant     = (op_b.exp != '0) ? {1'b1, op_b.frac} : '0;
        a_big      = {op_a.exp, a_mant} >= {op_b.exp, b_mant};
        big_exp    = a_big ? op_a.exp : op_b.exp;
        diff       = a_big ? (op_a.exp - op_b.exp) : (op_b.exp - op_a.exp);
        small_mant = a_big ? b_mant : a_mant;
        if (diff >= 8'd25) small_mant = '0;
        else               small_mant = small_mant >> diff;
    end

    // Normalisation: carry shifts right, otherwise shift the leading one up to bit 23.
    logic [LZ_W-1:0]   lz;
    logic [9:0]        nrm_exp_c;
    logic [FRAC_W-1:0] nrm_frac_c;

    fp32_lzc u_lzc (
        .value (sum_mant),
        .count (lz)
    );

    always_comb begin
        if (sum_mant[SUM_W-1]) begin
            nrm_exp_c  = {2'b00, sum_exp} + 10'd1;
            nrm_frac_c = sum_mant[SUM_W-2:1];
        end else begin
            nrm_exp_c  = {2'b00, sum_exp} + 10'd1 - {5'b00000, lz};
            nrm_frac_c = FRAC_W'(sum_mant << (lz - 5'd1));
        end
    end

    logic            ovf_c, unf_c;
    logic [XLEN-1:0] result_c;

    always_comb begin
        ovf_c = !nrm_zero && ($signed(nrm_exp) >= 10'sd255);
        unf_c = !nrm_zero && ($signed(nrm_exp) <= 10'sd0);
        if (exception)     result_c = QNAN;
        else if (nrm_zero) result_c = '0;
        else if (ovf_c)    result_c = pack(nrm_sign, 8'hFF, '0);
        else if (unf_c)    result_c = '0;
        else               result_c = pack(nrm_sign, nrm_exp[EXP_W-1:0], nrm_frac);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a      <= '0;
            op_b      <= '0;
            al_sign   <= 1'b0;
            al_sub    <= 1'b0;
            al_exp    <= '0;
            al_big    <= '0;
            al_small  <= '0;
            sum_sign  <= 1'b0;
            sum_exp   <= '0;
            sum_mant  <= '0;
            nrm_sign  <= 1'b0;
            nrm_zero  <= 1'b0;
            nrm_exp   <= '0;
            nrm_frac  <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            exception <= 1'b0;
        end else if (bus.clear) begin
            acc       <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            exception <= 1'b0;
        end else begin
            out_valid <= (state == ST_WRITE);
            case (state)
                ST_IDLE: if (transfer) begin
                    op_a <= unpack(bus.in_data);
                    op_b <= unpack(acc);
                    if (unpack(bus.in_data).exp == 8'hFF) exception <= 1'b1;
                end
                ST_ALIGN: begin
                    al_sign  <= a_big ? op_a.sign : op_b.sign;
                    al_sub   <= op_a.sign ^ op_b.sign;
                    al_exp   <= big_exp;
                    al_big   <= a_big ? a_mant : b_mant;
                    al_small <= small_mant;
                end
                ST_ADD: begin
                    sum_sign <= al_sign;
                    sum_exp  <= al_exp;
                    sum_mant <= al_sub ? ({1'b0, al_big} - {1'b0, al_small})
                                       : ({1'b0, al_big} + {1'b0, al_small});
                end
                ST_NORM: begin
                    nrm_sign <= sum_sign;
                    nrm_zero <= (sum_mant == '0);
                    nrm_exp  <= nrm_exp_c;
                    nrm_frac <= nrm_frac_c;
                end
                ST_WRITE: begin
                    acc       <= result_c;
                    overflow  <= overflow  | (ovf_c & !exception);
                    underflow <= underflow | (unf_c & !exception);
                end
                default: ;
            endcase
        end
    end
endmodule
